// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: stack-pointer op encodings and default sizes.
package operand_stack_pkg;

  localparam int STACK_DEPTH = 16;
  localparam int DATA_W      = 8;

  typedef enum logic [1:0] {
    DES_2 = 2'b00,
    DES_1 = 2'b01,
    ADV_0 = 2'b10,
    ADV_1 = 2'b11
  } sp_op_e;

endpackage

// File: rtl/operand_stack_sp_unit.sv
// Combinational stack-pointer unit: new depth, write target and legality of one op.
module sp_unit
  import operand_stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int PW    = $clog2(DEPTH) + 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [PW-1:0] depth,
  input  logic [1:0]    sp_op,
  input  logic          wr_en,
  input  logic          op_valid,
  output logic [PW-1:0] nd,
  output logic          do_write,
  output logic [AW-1:0] write_idx,
  output logic          ovf,
  output logic          udf
);

  // Illegal ops keep nd at the current depth and suppress the write.
  always_comb begin
    nd       = depth;
    do_write = 1'b0;
    ovf      = 1'b0;
    udf      = 1'b0;
    if (op_valid) begin
      case (sp_op_e'(sp_op))
        DES_2: begin
          if (depth >= (wr_en ? PW'(3) : PW'(2))) begin
            nd       = depth - PW'(2);
            do_write = wr_en;
          end else begin
            udf = 1'b1;
          end
        end
        DES_1: begin
          if (depth >= (wr_en ? PW'(2) : PW'(1))) begin
            nd       = depth - PW'(1);
            do_write = wr_en;
          end else begin
            udf = 1'b1;
          end
        end
        ADV_0: begin
          if (!wr_en) begin
            nd = depth;
          end else if (depth >= PW'(1)) begin
            do_write = 1'b1;
          end else begin
            udf = 1'b1;
          end
        end
        ADV_1: begin
          if (depth < PW'(DEPTH)) begin
            nd       = depth + PW'(1);
            do_write = 1'b1;
          end else begin
            ovf = 1'b1;
          end
        end
        default: begin
          nd = depth;
        end
      endcase
    end else begin
      nd = depth;
    end
  end

  // Only meaningful when do_write is set, which implies nd >= 1.
  assign write_idx = AW'(nd - PW'(1));

endmodule

// File: rtl/operand_stack.sv
// Operand stack: storage, depth register and sticky error flags; pointer logic lives in sp_unit.
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int DW    = DATA_W,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  input  logic [1:0]    sp_op,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          err_clr,
  output logic [DW-1:0] top_st,
  output logic [DW-1:0] snd_st,
  output logic [PW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          err_ovf,
  output logic          err_udf
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] depth_q, depth_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_udf_q, err_udf_d;

  logic [PW-1:0] nd;
  logic          do_write;
  logic [AW-1:0] write_idx;
  logic          ovf, udf;

  sp_unit #(.DEPTH(DEPTH), .PW(PW), .AW(AW)) u_sp_unit (
    .depth     (depth_q),
    .sp_op     (sp_op),
    .wr_en     (wr_en),
    .op_valid  (op_valid),
    .nd        (nd),
    .do_write  (do_write),
    .write_idx (write_idx),
    .ovf       (ovf),
    .udf       (udf)
  );

  // Next-state: storage write, depth update, and flags where a new error beats err_clr.
  always_comb begin
    mem_d   = mem_q;
    depth_d = nd;
    if (do_write) begin
      mem_d[write_idx] = wr_data;
    end else begin
      mem_d = mem_q;
    end
    if (ovf) begin
      err_ovf_d = 1'b1;
    end else if (err_clr) begin
      err_ovf_d = 1'b0;
    end else begin
      err_ovf_d = err_ovf_q;
    end
    if (udf) begin
      err_udf_d = 1'b1;
    end else if (err_clr) begin
      err_udf_d = 1'b0;
    end else begin
      err_udf_d = err_udf_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      depth_q   <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      depth_q   <= depth_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  // Popped entries keep stale data, so reads outside the live range are masked.
  assign top_st  = (depth_q >= PW'(1)) ? mem_q[AW'(depth_q - PW'(1))] : {DW{1'b0}};
  assign snd_st  = (depth_q >= PW'(2)) ? mem_q[AW'(depth_q - PW'(2))] : {DW{1'b0}};
  assign depth   = depth_q;
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == PW'(DEPTH));
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: a behavioural model queues expected state per op.
module tb_operand_stack;
  import operand_stack_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int PW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [1:0]    sp_op = 2'b10;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = 8'h00;
  logic          err_clr = 1'b0;
  logic [DW-1:0] top_st, snd_st;
  logic [PW-1:0] depth;
  logic          empty, full, err_ovf, err_udf;

  operand_stack #(.DEPTH(DEPTH), .DW(DW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .sp_op(sp_op), .wr_en(wr_en),
    .wr_data(wr_data), .err_clr(err_clr), .top_st(top_st), .snd_st(snd_st),
    .depth(depth), .empty(empty), .full(full), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] snd;
    logic [4:0] dep;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] m_mem [DEPTH];
  int         m_depth;
  bit         m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_depth = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.top = (m_depth >= 1) ? m_mem[m_depth-1] : 8'h00;
    e.snd = (m_depth >= 2) ? m_mem[m_depth-2] : 8'h00;
    e.dep = 5'(m_depth);
    e.emp = (m_depth == 0);
    e.ful = (m_depth == DEPTH);
    e.ovf = m_ovf;
    e.udf = m_udf;
    return e;
  endfunction

  task automatic model_apply(input logic v, input logic [1:0] op, input logic we,
                             input logic [7:0] d, input logic clr);
    int need = 0;
    int nd   = m_depth;
    bit wr   = 1'b0;
    bit ok   = 1'b1;
    bit n_ov = 1'b0;
    bit n_ud = 1'b0;
    if (v) begin
      case (op)
        2'b00: begin need = we ? 3 : 2; nd = m_depth - 2; wr = we; end
        2'b01: begin need = we ? 2 : 1; nd = m_depth - 1; wr = we; end
        2'b10: begin need = we ? 1 : 0; nd = m_depth;     wr = we; end
        default: begin need = 0; nd = m_depth + 1; wr = 1'b1; end
      endcase
      if (op == 2'b11) begin
        ok = (m_depth < DEPTH);
        n_ov = !ok;
      end else begin
        ok = (m_depth >= need);
        n_ud = !ok;
      end
      if (ok) begin
        if (wr) m_mem[nd-1] = d;
        m_depth = nd;
      end
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    m_ovf = m_ovf | n_ov;
    m_udf = m_udf | n_ud;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got depth 0x%0h expected an entry", tag, depth);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".top"},   32'(top_st),  32'(e.top));
      check({tag, ".snd"},   32'(snd_st),  32'(e.snd));
      check({tag, ".depth"}, 32'(depth),   32'(e.dep));
      check({tag, ".empty"}, 32'(empty),   32'(e.emp));
      check({tag, ".full"},  32'(full),    32'(e.ful));
      check({tag, ".ovf"},   32'(err_ovf), 32'(e.ovf));
      check({tag, ".udf"},   32'(err_udf), 32'(e.udf));
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] op, input logic we,
                      input logic [7:0] d, input logic clr);
    @(negedge clk);
    op_valid = v;
    sp_op    = op;
    wr_en    = we;
    wr_data  = d;
    err_clr  = clr;
    model_apply(v, op, we, d, clr);
    exp_q.push_back(model_view());
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    wr_en    = 1'b0;
    err_clr  = 1'b0;
    compare_out(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(model_view());
    compare_out("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 1'b0, ADV_1, 1'b1, 8'h99, 1'b0);

    // Push, push, add.
    step("push5", 1'b1, ADV_1, 1'b0, 8'h05, 1'b0);
    check("push5.depth_tp", 32'(depth), 32'd1);
    step("push3", 1'b1, ADV_1, 1'b0, 8'h03, 1'b0);
    check("push3.top_tp", 32'(top_st), 32'h03);
    check("push3.snd_tp", 32'(snd_st), 32'h05);
    step("add", 1'b1, DES_1, 1'b1, 8'h08, 1'b0);
    check("add.top_tp", 32'(top_st), 32'h08);
    check("add.snd_tp", 32'(snd_st), 32'h00);
    step("pop", 1'b1, DES_1, 1'b0, 8'h00, 1'b0);

    // Fill to full, then overflow.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, ADV_1, 1'b0, 8'(8'h10 + i), 1'b0);
    step("ovf", 1'b1, ADV_1, 1'b1, 8'hAA, 1'b0);
    check("ovf.full_tp", 32'(full), 32'd1);
    check("ovf.depth_tp", 32'(depth), 32'd16);
    check("ovf.flag_tp", 32'(err_ovf), 32'd1);
    check("ovf.top_tp", 32'(top_st), 32'h1F);
    step("clr_ovf", 1'b0, ADV_0, 1'b0, 8'h00, 1'b1);
    check("clr_ovf.flag_tp", 32'(err_ovf), 32'd0);

    // Drain to depth 1 and exercise underflow rules.
    for (int i = 0; i < DEPTH - 1; i++) step("drain", 1'b1, DES_1, 1'b0, 8'h00, 1'b0);
    step("des2_udf", 1'b1, DES_2, 1'b0, 8'h00, 1'b0);
    check("des2_udf.flag_tp", 32'(err_udf), 32'd1);
    check("des2_udf.depth_tp", 32'(depth), 32'd1);
    step("des1w_udf", 1'b1, DES_1, 1'b1, 8'h55, 1'b0);
    check("des1w_udf.depth_tp", 32'(depth), 32'd1);
    step("adv0w", 1'b1, ADV_0, 1'b1, 8'h7E, 1'b0);
    check("adv0w.top_tp", 32'(top_st), 32'h7E);
    step("clr_udf", 1'b0, ADV_0, 1'b0, 8'h00, 1'b1);
    step("to_empty", 1'b1, DES_1, 1'b0, 8'h00, 1'b0);
    step("clr_vs_err", 1'b1, DES_1, 1'b0, 8'h00, 1'b1);
    check("clr_vs_err.flag_tp", 32'(err_udf), 32'd1);
    step("adv0_nop_empty", 1'b1, ADV_0, 1'b0, 8'h00, 1'b1);

    // Async reset mid-cycle at depth 5.
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, ADV_1, 1'b0, 8'(8'h60 + i), 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.depth", 32'(depth), 32'd0);
    check("arst.top", 32'(top_st), 32'h00);
    check("arst.empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, ADV_1, 1'b0, 8'h42, 1'b0);
    check("post_rst.top_tp", 32'(top_st), 32'h42);
    check("post_rst.depth_tp", 32'(depth), 32'd1);

    // Random ops against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Hardware operand stack for the 8-bit stack machine; the consumer of the stack-pointer op codes (DES_2/DES_1/ADV_0/ADV_1) that the control decoder emits.
- Holds the operand stack and exposes top-of-stack and second-of-stack to the ALU, the mux trees and DMEM.
- Applies one pointer operation per cycle, with optional write-back of the ALU/DMEM/IMEM result to the new top.
- Detects and flags overflow and underflow.

Parameters:
- DEPTH, 16, number of 8-bit stack entries. Must be a power of 2 and at least 4.
- DW, 8, data width.
- PW, $clog2(DEPTH)+1, depth counter width (holds 0..DEPTH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  apply sp_op this cycle
- sp_op  in  2  DES_2=00, DES_1=01, ADV_0=10, ADV_1=11
- wr_en  in  1  write wr_data to the new top after pointer adjustment
- wr_data  in  DW  write-back value (mux2 output)
- err_clr  in  1  clear sticky error flags
- top_st  out  DW  entry at depth-1; 0 when empty
- snd_st  out  DW  entry at depth-2; 0 when depth<2
- depth  out  PW  current occupancy
- empty  out  1  depth==0
- full  out  1  depth==DEPTH
- err_ovf  out  1  sticky overflow flag
- err_udf  out  1  sticky underflow flag

Behaviour:
- Reset (async, rst_n low): depth=0, all entries=0, err_ovf=err_udf=0. Resulting outputs: top_st=0, snd_st=0, empty=1, full=0.
  - Asserting rst_n mid-operation discards any pending op; the first op is accepted on the first rising edge after deassertion.
- Op semantics when op_valid=1 (nd = new depth):
  - DES_2: nd=depth-2.
  - DES_1: nd=depth-1.
  - ADV_0: nd=depth.
  - ADV_1: nd=depth+1, and wr_data is always written to the new top (wr_en is don't-care).
  - For DES_2, DES_1 and ADV_0, if wr_en=1 then entry[nd-1] <= wr_data.
- Legality rules (checked against the pre-op depth):
  - DES_2 needs depth>=2, or depth>=3 if wr_en.
  - DES_1 needs depth>=1, or depth>=2 if wr_en (binary ALU op: pop 2, push 1).
  - ADV_0 with wr_en needs depth>=1. ADV_0 without wr_en is a NOP and always legal.
  - ADV_1 needs depth<DEPTH.
- Illegal op: depth and storage are unchanged. Set err_udf (DES cases, and ADV_0 with wr_en) or err_ovf (ADV_1). Flags are set on the same edge.
- op_valid=0: no state change; wr_en is ignored.
- Latency:
  - All updates commit on the rising clk edge.
  - top_st, snd_st, depth, empty and full are combinational decodes of registered state, so they reflect the op in the cycle after the edge.
  - There is no internal bypass; the controller sequences one op per cycle.
- Popped entries keep stale data in storage but are never visible: top_st and snd_st are masked to 0 outside the valid range.
- err_clr and a new error on the same edge: the flag is set (error wins). err_clr alone clears both flags.
- Flags do not block further ops. Legal ops continue to execute while a flag is set.
- Depth arithmetic is PW bits wide. No wrap-around is possible because illegal ops are suppressed.

Decomposition:
- SP op encodings (DES_2, DES_1, ADV_0, ADV_1) stay in the shared definitions package.
- Add a STACK_DEPTH constant to the package, used as the default for DEPTH.
- Sub-module sp_unit: combinational. Takes depth, sp_op, wr_en and op_valid; returns nd, do_write, write_idx, ovf and udf.
- operand_stack instantiates sp_unit and owns the storage and the flag registers.

Test Plan (DEPTH=16):
- Reset then idle: top_st=0, snd_st=0, depth=0, empty=1, err_ovf=err_udf=0.
- ADV_1 with wr_data=0x05, then ADV_1 with wr_data=0x03, then DES_1 with wr_en=1, wr_data=0x08 (ADD): depth 1 then 2 then 1; after the second push top_st=0x03 and snd_st=0x05; final top_st=0x08, snd_st=0.
- Push 16 values 0x10..0x1F then one more ADV_1 with wr_data=0xAA: full=1, depth=16, err_ovf=1, top_st=0x1F. Follow with err_clr: err_ovf=0.
- From depth=1: DES_2 gives err_udf=1, depth stays 1. Then DES_1 with wr_en=1 gives err_udf=1, depth 1. Then ADV_0 with wr_en=1, wr_data=0x7E gives top_st=0x7E, depth 1.
- Same-cycle err_clr=1 with an illegal DES_1 at depth=0: err_udf=1 after the edge.
- Assert rst_n low asynchronously mid-cycle at depth=5: depth=0 and top_st=0 immediately, without waiting for a clk edge. After release, ADV_1 with wr_data=0x42 gives depth=1, top_st=0x42.
